// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for a multi-cycle datapath.
// Walks RESET -> T0..T7 -> HALT and decodes state + ir into datapath strobes.
// Ports:
//   clk, clr (async, active-low reset)
//   ir[31:0] current instruction
//   con_ff   branch condition flag
//   mem_ready memory handshake
//   datapath/register/ALU strobes, alu_control[4:0], run
module control_sequencer (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        mem_ready,
    output logic        Pout,
    output logic        Pen,
    output logic        MARen,
    output logic        MDRen,
    output logic        MDROut,
    output logic        IRen,
    output logic        Read,
    output logic        Write,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Cout,
    output logic        ConIn,
    output logic        Yen,
    output logic        ZLOen,
    output logic        ZHIen,
    output logic        ZLOout,
    output logic        ZHIout,
    output logic        HIen,
    output logic        LOen,
    output logic        HIout,
    output logic        LOout,
    output logic        IncPC,
    output logic [4:0]  alu_control,
    output logic        run
);

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3,
        S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [4:0] ALU_ADD = 5'b00011;

    state_t     state_q, state_d;
    logic [4:0] op;
    logic       is_alu, is_imm, is_ldi, is_ld, is_st;
    logic       is_dm, is_br, is_jr, is_mfhi, is_mflo, is_halt;
    logic       has_exec;

    // Register fields are routed by Gra/Grb/Grc in the datapath, not here.
    logic       unused_ir_bits;
    assign unused_ir_bits = ^ir[26:0];

    assign op      = ir[31:27];
    assign is_ld   = (op == 5'b00000);
    assign is_ldi  = (op == 5'b00001);
    assign is_st   = (op == 5'b00010);
    assign is_alu  = (op >= 5'b00011) && (op <= 5'b01011);
    assign is_imm  = (op >= 5'b01100) && (op <= 5'b01110);
    assign is_dm   = (op == 5'b01111) || (op == 5'b10000);
    assign is_br   = (op == 5'b10011);
    assign is_jr   = (op == 5'b10100);
    assign is_mfhi = (op == 5'b11000);
    assign is_mflo = (op == 5'b11001);
    assign is_halt = (op == 5'b11011);

    // nop and undefined opcodes have no execute phase.
    assign has_exec = is_ld | is_ldi | is_st | is_alu | is_imm | is_dm
                    | is_br | is_jr | is_mfhi | is_mflo;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RESET: state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = mem_ready ? S_T2 : S_T1;
            S_T2: begin
                if (is_halt)       state_d = S_HALT;
                else if (has_exec) state_d = S_T3;
                else               state_d = S_T0;
            end
            S_T3: begin
                if (is_jr || is_mfhi || is_mflo) state_d = S_T0;
                else                             state_d = S_T4;
            end
            S_T4:    state_d = S_T5;
            S_T5: begin
                if (is_ld || is_st || is_dm || is_br) state_d = S_T6;
                else                                  state_d = S_T0;
            end
            S_T6: begin
                if (is_ld)      state_d = mem_ready ? S_T7 : S_T6;
                else if (is_st) state_d = S_T7;
                else            state_d = S_T0;
            end
            S_T7: begin
                if (is_st) state_d = mem_ready ? S_T0 : S_T7;
                else       state_d = S_T0;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state_q <= S_RESET;
        else      state_q <= state_d;
    end

    always_comb begin
        {Pout, Pen, MARen, MDRen, MDROut, IRen, Read, Write} = '0;
        {Gra, Grb, Grc, Rin, Rout, BAout, Cout, ConIn}       = '0;
        {Yen, ZLOen, ZHIen, ZLOout, ZHIout}                  = '0;
        {HIen, LOen, HIout, LOout, IncPC}                    = '0;
        alu_control = 5'b00000;
        run = (state_q != S_RESET) && (state_q != S_HALT);
        unique case (state_q)
            S_T0: begin
                Pout = 1'b1; MARen = 1'b1; IncPC = 1'b1;
                ZLOen = 1'b1; alu_control = ALU_ADD;
            end
            S_T1: begin
                ZLOout = 1'b1; Pen = 1'b1;
                Read = 1'b1; MDRen = 1'b1;
            end
            S_T2: begin
                MDROut = 1'b1; IRen = 1'b1;
            end
            S_T3: begin
                if (is_alu || is_imm) begin
                    Grb = 1'b1; Rout = 1'b1; Yen = 1'b1;
                end else if (is_ldi || is_ld || is_st) begin
                    Grb = 1'b1; BAout = 1'b1; Yen = 1'b1;
                end else if (is_dm) begin
                    Gra = 1'b1; Rout = 1'b1; Yen = 1'b1;
                end else if (is_br) begin
                    Gra = 1'b1; Rout = 1'b1; ConIn = 1'b1;
                end else if (is_jr) begin
                    Gra = 1'b1; Rout = 1'b1; Pen = 1'b1;
                end else if (is_mfhi) begin
                    Gra = 1'b1; Rin = 1'b1; HIout = 1'b1;
                end else if (is_mflo) begin
                    Gra = 1'b1; Rin = 1'b1; LOout = 1'b1;
                end
            end
            S_T4: begin
                if (is_alu || is_imm) begin
                    Cout = is_imm;
                    Grc = !is_imm; Rout = !is_imm;
                    ZLOen = 1'b1; alu_control = op;
                end else if (is_ldi || is_ld || is_st) begin
                    Cout = 1'b1; ZLOen = 1'b1;
                    alu_control = ALU_ADD;
                end else if (is_dm) begin
                    Grb = 1'b1; Rout = 1'b1;
                    ZLOen = 1'b1; ZHIen = 1'b1;
                    alu_control = op;
                end else if (is_br) begin
                    Pout = 1'b1; Yen = 1'b1;
                end
            end
            S_T5: begin
                if (is_alu || is_imm || is_ldi) begin
                    ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_ld || is_st) begin
                    ZLOout = 1'b1; MARen = 1'b1;
                end else if (is_dm) begin
                    ZLOout = 1'b1; LOen = 1'b1;
                end else if (is_br) begin
                    Cout = 1'b1; ZLOen = 1'b1;
                    alu_control = ALU_ADD;
                end
            end
            S_T6: begin
                if (is_ld) begin
                    Read = 1'b1; MDRen = 1'b1;
                end else if (is_st) begin
                    Gra = 1'b1; Rout = 1'b1; MDRen = 1'b1;
                end else if (is_dm) begin
                    ZHIout = 1'b1; HIen = 1'b1;
                end else if (is_br) begin
                    ZLOout = con_ff; Pen = con_ff;
                end
            end
            S_T7: begin
                if (is_ld) begin
                    MDROut = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_st) begin
                    Write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized scoreboard bench for control_sequencer.
// A table-style reference plans per-cycle expected strobes per instruction.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] ir = '0;
    logic        con_ff = 1'b0;
    logic        mem_ready = 1'b0;
    logic Pout, Pen, MARen, MDRen, MDROut, IRen, Read, Write;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, ConIn;
    logic Yen, ZLOen, ZHIen, ZLOout, ZHIout;
    logic HIen, LOen, HIout, LOout, IncPC;
    logic [4:0] alu_control;
    logic run;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff),
        .mem_ready(mem_ready),
        .Pout(Pout), .Pen(Pen), .MARen(MARen), .MDRen(MDRen),
        .MDROut(MDROut), .IRen(IRen), .Read(Read), .Write(Write),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .BAout(BAout), .Cout(Cout), .ConIn(ConIn),
        .Yen(Yen), .ZLOen(ZLOen), .ZHIen(ZHIen), .ZLOout(ZLOout),
        .ZHIout(ZHIout), .HIen(HIen), .LOen(LOen), .HIout(HIout),
        .LOout(LOout), .IncPC(IncPC),
        .alu_control(alu_control), .run(run)
    );

    // Bit map of the observed output word.
    localparam logic [31:0] INCPC  = 32'd1 << 0;
    localparam logic [31:0] LOOUT  = 32'd1 << 1;
    localparam logic [31:0] HIOUT  = 32'd1 << 2;
    localparam logic [31:0] LOEN   = 32'd1 << 3;
    localparam logic [31:0] HIEN   = 32'd1 << 4;
    localparam logic [31:0] ZHIOUT = 32'd1 << 5;
    localparam logic [31:0] ZLOOUT = 32'd1 << 6;
    localparam logic [31:0] ZHIEN  = 32'd1 << 7;
    localparam logic [31:0] ZLOEN  = 32'd1 << 8;
    localparam logic [31:0] YEN    = 32'd1 << 9;
    localparam logic [31:0] CONIN  = 32'd1 << 10;
    localparam logic [31:0] COUT   = 32'd1 << 11;
    localparam logic [31:0] BAOUT  = 32'd1 << 12;
    localparam logic [31:0] ROUT   = 32'd1 << 13;
    localparam logic [31:0] RIN    = 32'd1 << 14;
    localparam logic [31:0] GRC    = 32'd1 << 15;
    localparam logic [31:0] GRB    = 32'd1 << 16;
    localparam logic [31:0] GRA    = 32'd1 << 17;
    localparam logic [31:0] WRITE  = 32'd1 << 18;
    localparam logic [31:0] READ   = 32'd1 << 19;
    localparam logic [31:0] IREN   = 32'd1 << 20;
    localparam logic [31:0] MDROUT = 32'd1 << 21;
    localparam logic [31:0] MDREN  = 32'd1 << 22;
    localparam logic [31:0] MAREN  = 32'd1 << 23;
    localparam logic [31:0] PEN    = 32'd1 << 24;
    localparam logic [31:0] POUT   = 32'd1 << 25;
    localparam logic [31:0] RUN    = 32'd1 << 31;

    logic [31:0] act;
    assign act = {run, alu_control, Pout, Pen, MARen, MDRen, MDROut,
                  IRen, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout,
                  Cout, ConIn, Yen, ZLOen, ZHIen, ZLOout, ZHIout,
                  HIen, LOen, HIout, LOout, IncPC};

    typedef struct {
        logic [31:0] ir;
        logic [31:0] exp;
        bit          mr;
        bit          clr;
        bit          con;
    } step_t;

    typedef struct {
        logic [31:0] exp;
        logic [4:0]  op;
        int          idx;
    } sb_t;

    step_t plan[$];
    sb_t   sb[$];
    logic [31:0] cur_ir;
    bit          cur_con;
    int          checks = 0;
    int          errors = 0;
    int          step_no = 0;

    function automatic logic [31:0] alu(input logic [4:0] a);
        return {1'b0, a, 26'b0};
    endfunction

    task automatic put(input logic [31:0] e, input bit mr);
        step_t s;
        s.ir = cur_ir; s.exp = e; s.mr = mr;
        s.clr = 1'b1; s.con = cur_con;
        plan.push_back(s);
    endtask

    task automatic put_any(input logic [31:0] e);
        put(e, 1'($urandom));
    endtask

    // Stay n extra cycles with mem_ready low, then one with it high.
    task automatic hold(input logic [31:0] e, input int n);
        for (int i = 0; i < n; i++) put(e, 1'b0);
        put(e, 1'b1);
    endtask

    task automatic push_reset();
        step_t s;
        s.ir = cur_ir; s.exp = '0; s.mr = 1'($urandom);
        s.clr = 1'b0; s.con = cur_con;
        plan.push_back(s);
        s.clr = 1'b1;
        plan.push_back(s);
    endtask

    // Reference: per-cycle strobe sets by instruction class.
    task automatic build(input logic [31:0] irv, input bit con,
                         input int w1, input int w6, input int w7);
        logic [4:0] op;
        op = irv[31:27];
        cur_ir = irv; cur_con = con;
        put_any(RUN | POUT | MAREN | INCPC | ZLOEN | alu(5'd3));
        hold(RUN | ZLOOUT | PEN | READ | MDREN, w1);
        put_any(RUN | MDROUT | IREN);
        if (op >= 5'd3 && op <= 5'd14) begin
            put_any(RUN | GRB | ROUT | YEN);
            if (op >= 5'd12)
                put_any(RUN | COUT | ZLOEN | alu(op));
            else
                put_any(RUN | GRC | ROUT | ZLOEN | alu(op));
            put_any(RUN | ZLOOUT | GRA | RIN);
        end else if (op <= 5'd2) begin
            put_any(RUN | GRB | BAOUT | YEN);
            put_any(RUN | COUT | ZLOEN | alu(5'd3));
            if (op == 5'd1) begin
                put_any(RUN | ZLOOUT | GRA | RIN);
            end else if (op == 5'd0) begin
                put_any(RUN | ZLOOUT | MAREN);
                hold(RUN | READ | MDREN, w6);
                put_any(RUN | MDROUT | GRA | RIN);
            end else begin
                put_any(RUN | ZLOOUT | MAREN);
                put_any(RUN | GRA | ROUT | MDREN);
                hold(RUN | WRITE, w7);
            end
        end else if (op == 5'd15 || op == 5'd16) begin
            put_any(RUN | GRA | ROUT | YEN);
            put_any(RUN | GRB | ROUT | ZLOEN | ZHIEN | alu(op));
            put_any(RUN | ZLOOUT | LOEN);
            put_any(RUN | ZHIOUT | HIEN);
        end else if (op == 5'd19) begin
            put_any(RUN | GRA | ROUT | CONIN);
            put_any(RUN | POUT | YEN);
            put_any(RUN | COUT | ZLOEN | alu(5'd3));
            put_any(con ? (RUN | ZLOOUT | PEN) : RUN);
        end else if (op == 5'd20) begin
            put_any(RUN | GRA | ROUT | PEN);
        end else if (op == 5'd24) begin
            put_any(RUN | GRA | RIN | HIOUT);
        end else if (op == 5'd25) begin
            put_any(RUN | GRA | RIN | LOOUT);
        end else if (op == 5'd27) begin
            for (int i = 0; i < 10; i++) put_any('0);
            push_reset();
        end
    endtask

    // Cut the planned instruction at step k and reset there.
    task automatic abort_at(input int k);
        while (plan.size() > k) void'(plan.pop_back());
        push_reset();
    endtask

    task automatic run_plan();
        sb_t e;
        foreach (plan[i]) begin
            @(posedge clk);
            #1;
            ir = plan[i].ir;
            con_ff = plan[i].con;
            mem_ready = plan[i].mr;
            clr = plan[i].clr;
            e.exp = plan[i].exp;
            e.op = plan[i].ir[31:27];
            e.idx = step_no;
            step_no++;
            sb.push_back(e);
        end
        plan.delete();
    endtask

    // Monitor: one expected word per cycle, compared mid-cycle.
    always @(negedge clk) begin
        sb_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL step %0d op=%b got=%h exp=%h",
                         e.idx, e.op, act, e.exp);
            end
        end
    end

    initial begin
        int k;
        logic [31:0] rir;
        cur_ir = '0; cur_con = 1'b0;
        push_reset();
        run_plan();

        build(32'h18918000, 1'b0, 0, 0, 0);
        run_plan();
        build(32'h18918000, 1'b0, 0, 0, 0);
        abort_at(4);
        run_plan();
        build({5'b00000, 27'h0123456}, 1'b0, 2, 3, 0);
        run_plan();
        build({5'b00010, 27'h0765432}, 1'b0, 1, 0, 2);
        run_plan();
        build({5'b10011, 27'h0111111}, 1'b0, 0, 0, 0);
        run_plan();
        build({5'b10011, 27'h0111111}, 1'b1, 0, 0, 0);
        run_plan();
        build({5'b10000, 27'h0222222}, 1'b0, 0, 0, 0);
        run_plan();
        build({5'b11011, 27'h0}, 1'b0, 0, 0, 0);
        run_plan();

        for (int n = 0; n < 250; n++) begin
            rir = $urandom;
            build(rir, 1'($urandom),
                  int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)));
            if ($urandom_range(0, 7) == 0) begin
                k = int'($urandom_range(0, plan.size() - 1));
                abort_at(k);
            end
            run_plan();
        end

        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
